led_refresh_ctrl: RTL and testbench

LED_REFRESH_CTRL -- requirements
Module: led_refresh_ctrl

---
 rtl/led_refresh_ctrl.sv | 140 ++++++++++++++
 tb/tb_led_refresh_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_refresh_ctrl.sv
// LED refresh controller: SFR-mapped shadow frame buffer, double-buffered
// into an active frame that is streamed pixel by pixel with a latch gap.
module led_refresh_ctrl #(
    parameter int NUM_LED      = 8,
    parameter int LATCH_CYCLES = 3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sfr_addr,
    input  logic        sfr_wr,
    input  logic        sfr_rd,
    input  logic [7:0]  sfr_data_in,
    output logic [7:0]  sfr_data_out,
    output logic        led_sfr_cs,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        frame_busy
);

    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

    state_t        state_q, state_d;
    logic          pending_q, pending_d;
    logic [2:0]    idx_q;
    logic          auto_q;
    logic [7:0]    red_q, grn_q;
    logic [7:0]    rdata_q, rdata_d;
    logic [2:0]    pix_cnt_q;
    logic [LW-1:0] lat_cnt_q;
    logic [23:0]   shadow_q [NUM_LED];
    logic [23:0]   active_q [NUM_LED];

    logic wr_ctl, commit, hs, last_pix, lat_done;

    assign led_sfr_cs = (sfr_addr >= 8'hC2) && (sfr_addr <= 8'hC6);
    assign wr_ctl     = sfr_wr && (sfr_addr == 8'hC2);
    assign commit     = wr_ctl && sfr_data_in[4];
    assign hs         = pix_valid && pix_ready;
    assign last_pix   = (pix_cnt_q == 3'(NUM_LED - 1));
    assign lat_done   = (lat_cnt_q == LW'(LATCH_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (commit || pending_q) state_d = LOAD;
            LOAD:    state_d = SEND;
            SEND:    if (hs && last_pix) state_d = LATCH;
            LATCH:   if (lat_done) state_d = (pending_q || auto_q) ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Entering LOAD consumes the pending flag; a commit seen outside IDLE
    // wins so that it always produces one more frame.
    always_comb begin
        pending_d = pending_q;
        if (state_d == LOAD) pending_d = 1'b0;
        if (commit && (state_q != IDLE)) pending_d = 1'b1;
    end

    always_comb begin
        pix_valid  = (state_q == SEND);
        pix_data   = (state_q == SEND) ? active_q[pix_cnt_q] : 24'h0;
        frame_busy = (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_q <= '0;
            lat_cnt_q <= '0;
        end else begin
            if (state_q == LOAD) pix_cnt_q <= '0;
            else if ((state_q == SEND) && hs)
                pix_cnt_q <= last_pix ? 3'd0 : pix_cnt_q + 3'd1;
            if ((state_q == LATCH) && !lat_done) lat_cnt_q <= lat_cnt_q + 1'b1;
            else lat_cnt_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            auto_q <= 1'b0;
            red_q  <= '0;
            grn_q  <= '0;
            for (int i = 0; i < NUM_LED; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (sfr_wr) begin
                case (sfr_addr)
                    8'hC2: begin
                        idx_q  <= sfr_data_in[2:0];
                        auto_q <= sfr_data_in[5];
                    end
                    8'hC3: red_q <= sfr_data_in;
                    8'hC4: grn_q <= sfr_data_in;
                    8'hC5: begin
                        shadow_q[idx_q] <= {grn_q, red_q, sfr_data_in};
                        idx_q <= (idx_q == 3'(NUM_LED - 1)) ? 3'd0 : idx_q + 3'd1;
                    end
                    default: ;
                endcase
            end
            if (state_q == LOAD) begin
                for (int i = 0; i < NUM_LED; i++) active_q[i] <= shadow_q[i];
            end
        end
    end

    always_comb begin
        case (sfr_addr)
            8'hC2:   rdata_d = {2'b00, auto_q, 2'b00, idx_q};
            8'hC6:   rdata_d = {6'b0, pending_q, frame_busy};
            default: rdata_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) rdata_q <= 8'h00;
        else if (sfr_rd) rdata_q <= rdata_d;
    end

    assign sfr_data_out = rdata_q;

endmodule

// File: tb/tb_led_refresh_ctrl.sv
// Scoreboard bench for led_refresh_ctrl: expected pixels and SFR read data
// are queued by the stimulus thread and checked by an independent monitor.
module tb_led_refresh_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sfr_addr;
    logic        sfr_wr, sfr_rd;
    logic [7:0]  sfr_data_in;
    logic [7:0]  sfr_data_out;
    logic        led_sfr_cs;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        frame_busy;

    led_refresh_ctrl dut (
        .clk(clk), .rst(rst), .sfr_addr(sfr_addr), .sfr_wr(sfr_wr),
        .sfr_rd(sfr_rd), .sfr_data_in(sfr_data_in),
        .sfr_data_out(sfr_data_out), .led_sfr_cs(led_sfr_cs),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .frame_busy(frame_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int hs_cnt = 0;
    logic rd_seen = 1'b0;
    logic [23:0] exp_q [$];
    logic [7:0]  rd_q  [$];
    logic [23:0] img  [8];
    logic [23:0] img2 [8];
    logic [23:0] img3 [8];
    logic [23:0] zero [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rd_seen <= sfr_rd;

    initial begin
        forever begin
            @(negedge clk);
            if (rd_seen) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 32'(sfr_data_out), 32'hDEAD);
                else chk("sfr_rd", 32'(sfr_data_out), 32'(rd_q.pop_front()));
            end
            if (pix_valid && pix_ready && !rst) begin
                hs_cnt++;
                if (exp_q.size() == 0) chk("pix_unexpected", 32'(pix_data), 32'hDEAD);
                else chk("pix", 32'(pix_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        sfr_addr = a; sfr_data_in = d; sfr_wr = 1'b1;
        tick;
        sfr_wr = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e);
        sfr_addr = a; sfr_rd = 1'b1;
        rd_q.push_back(e);
        tick;
        sfr_rd = 1'b0;
    endtask

    task automatic load_img(input logic [23:0] p [8]);
        wr(8'hC2, 8'h00);
        for (int i = 0; i < 8; i++) begin
            wr(8'hC3, p[i][15:8]);
            wr(8'hC4, p[i][23:16]);
            wr(8'hC5, p[i][7:0]);
        end
    endtask

    task automatic push_frame(input logic [23:0] p [8]);
        for (int i = 0; i < 8; i++) exp_q.push_back(p[i]);
    endtask

    task automatic wait_hs(input int n, input int budget);
        int k = 0;
        while (hs_cnt < n && k < budget) begin tick; k++; end
        chk("wait_hs", 32'(hs_cnt), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (frame_busy && k < budget) begin tick; k++; end
        chk("wait_idle", 32'(frame_busy), 32'd0);
    endtask

    initial begin
        int n, nv;
        img  = '{24'h201030, 24'h211131, 24'h221232, 24'h231333,
                 24'h241434, 24'h251535, 24'h261636, 24'h271737};
        img2 = '{24'hBBAACC, 24'h211131, 24'h221232, 24'h231333,
                 24'h241434, 24'h251535, 24'h261636, 24'h271737};
        img3 = '{24'h887799, 24'h211131, 24'h221232, 24'h231333,
                 24'h241434, 24'h251535, 24'h261636, 24'h554466};
        zero = '{default: 24'h0};

        rst = 1'b1; sfr_addr = 8'h00; sfr_wr = 1'b0; sfr_rd = 1'b0;
        sfr_data_in = 8'h00; pix_ready = 1'b1;
        repeat (3) tick;
        chk("rst_valid", 32'(pix_valid), 0);
        chk("rst_data", 32'(pix_data), 0);
        chk("rst_busy", 32'(frame_busy), 0);
        chk("rst_dout", 32'(sfr_data_out), 0);
        rst = 1'b0;
        tick;

        sfr_addr = 8'hC1; #1 chk("cs_C1", 32'(led_sfr_cs), 0);
        sfr_addr = 8'hC2; #1 chk("cs_C2", 32'(led_sfr_cs), 1);
        sfr_addr = 8'hC6; #1 chk("cs_C6", 32'(led_sfr_cs), 1);
        sfr_addr = 8'hC7; #1 chk("cs_C7", 32'(led_sfr_cs), 0);
        tick;

        // Single commit: one pixel set, ready tied high
        wr(8'hC2, 8'h00);
        wr(8'hC3, 8'h11);
        wr(8'hC4, 8'h22);
        wr(8'hC5, 8'h33);
        exp_q.push_back(24'h221133);
        for (int i = 0; i < 7; i++) exp_q.push_back(24'h0);
        hs_cnt = 0;
        wr(8'hC2, 8'h10);
        n = 0; nv = 0;
        while (frame_busy && n < 5000) begin
            n++;
            if (pix_valid) nv++;
            tick;
        end
        chk("frame_len", 32'(n), 32'd3009);
        chk("valid_cycles", 32'(nv), 32'd8);
        chk("q_empty1", 32'(exp_q.size()), 0);
        rd(8'hC6, 8'h00);
        rd(8'hC2, 8'h00);
        rd(8'hC3, 8'h00);

        // Backpressure on pixel 3, also wraps idx after eight C5 writes
        load_img(img);
        rd(8'hC2, 8'h00);
        push_frame(img);
        hs_cnt = 0;
        wr(8'hC2, 8'h10);
        wait_hs(3, 100);
        pix_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(pix_valid), 1);
            chk("stall_data", 32'(pix_data), 32'h231333);
            tick;
        end
        chk("stall_hs", 32'(hs_cnt), 3);
        pix_ready = 1'b1;
        wait_idle(5000);
        chk("bp_hs", 32'(hs_cnt), 8);
        chk("q_empty2", 32'(exp_q.size()), 0);

        // Three commits during SEND plus a shadow edit for the next frame
        push_frame(img);
        hs_cnt = 0;
        wr(8'hC2, 8'h10);
        wait_hs(2, 100);
        wr(8'hC2, 8'h10);
        wr(8'hC2, 8'h10);
        wr(8'hC2, 8'h10);
        rd(8'hC6, 8'h03);
        wr(8'hC3, 8'hAA);
        wr(8'hC4, 8'hBB);
        wr(8'hC5, 8'hCC);
        push_frame(img2);
        wait_idle(10000);
        repeat (20) tick;
        chk("pend_hs", 32'(hs_cnt), 16);
        chk("q_empty3", 32'(exp_q.size()), 0);
        rd(8'hC6, 8'h00);

        // Auto-refresh: gap between frames is LATCH (3000) plus LOAD (1)
        push_frame(img2);
        push_frame(img2);
        hs_cnt = 0;
        wr(8'hC2, 8'h30);
        rd(8'hC2, 8'h20);
        wait_hs(8, 100);
        n = 0;
        while (!pix_valid && n < 5000) begin
            if (!frame_busy) chk("auto_busy", 32'(frame_busy), 1);
            n++;
            tick;
        end
        chk("auto_gap", 32'(n), 32'd3001);
        wr(8'hC2, 8'h00);
        wait_idle(5000);
        repeat (20) tick;
        chk("auto_hs", 32'(hs_cnt), 16);
        chk("q_empty4", 32'(exp_q.size()), 0);
        rd(8'hC2, 8'h00);

        // Index wrap from 7 to 0
        wr(8'hC2, 8'h07);
        wr(8'hC3, 8'h44);
        wr(8'hC4, 8'h55);
        wr(8'hC5, 8'h66);
        wr(8'hC3, 8'h77);
        wr(8'hC4, 8'h88);
        wr(8'hC5, 8'h99);
        rd(8'hC2, 8'h01);
        push_frame(img3);
        hs_cnt = 0;
        wr(8'hC2, 8'h10);
        wait_idle(5000);
        chk("q_empty5", 32'(exp_q.size()), 0);

        // Reset while pixel 4 is on the bus
        push_frame(img3);
        hs_cnt = 0;
        wr(8'hC2, 8'h30);
        wait_hs(4, 100);
        chk("pre_rst_data", 32'(pix_data), 32'h241434);
        rst = 1'b1;
        tick;
        chk("abort_valid", 32'(pix_valid), 0);
        chk("abort_busy", 32'(frame_busy), 0);
        chk("abort_data", 32'(pix_data), 0);
        chk("abort_dout", 32'(sfr_data_out), 0);
        exp_q.delete();
        tick;
        rst = 1'b0;
        rd(8'hC2, 8'h00);
        rd(8'hC6, 8'h00);
        rd(8'hC4, 8'h00);
        push_frame(zero);
        hs_cnt = 0;
        wr(8'hC2, 8'h10);
        wait_idle(5000);
        chk("post_rst_hs", 32'(hs_cnt), 8);
        chk("q_empty6", 32'(exp_q.size()), 0);
        tick;
        tick;
        chk("rd_q_empty", 32'(rd_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
